// File: rtl/crossroad1_core_cpu_0_oci_pkg.sv
// Shared definitions for the OCI data-trace packing path.
//   SYM_W    : bits per trace symbol
//   BUF_SYMS : symbol capacity of the packing buffer
//   CNT_W    : width of symbol counts (2^CNT_W > BUF_SYMS)
//   BUF_W    : packing buffer width in bits
//   GRP_SYMS : maximum symbols per input group
package crossroad1_core_cpu_0_oci_pkg;

    localparam int SYM_W    = 2;
    localparam int BUF_SYMS = 15;
    localparam int CNT_W    = 4;
    localparam int BUF_W    = SYM_W * BUF_SYMS;
    localparam int GRP_SYMS = 3;
    localparam int GRP_W    = SYM_W * GRP_SYMS;

    typedef logic [SYM_W-1:0] trace_sym_t;
    typedef logic [CNT_W-1:0] dct_cnt_t;

    // Evaluated one bit wider than a count so that 14 + 3 cannot wrap and
    // falsely report room in the buffer.
    function automatic logic grp_fits(input dct_cnt_t cnt, input logic [1:0] add);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(add);
        return sum <= (CNT_W+1)'(BUF_SYMS);
    endfunction

endpackage

// File: rtl/crossroad1_core_cpu_0_oci_dct_insert.sv
// Places a group of up to three trace symbols at a symbol offset inside a
// buffer-wide word. Symbols beyond grp_cnt are forced to zero so stale
// upper bits of the input never leak into the buffer.
//   grp_syms : packed group, symbol 0 in the low bits
//   grp_cnt  : number of valid symbols in the group (0..3)
//   offset   : destination symbol position
//   placed   : BUF_W word holding only the placed group
module crossroad1_core_cpu_0_oci_dct_insert
    import crossroad1_core_cpu_0_oci_pkg::*;
(
    input  logic [GRP_W-1:0] grp_syms,
    input  logic [1:0]       grp_cnt,
    input  dct_cnt_t         offset,
    output logic [BUF_W-1:0] placed
);

    logic [GRP_W-1:0] masked;
    logic [7:0]       shamt;

    always_comb begin
        masked = '0;
        for (int i = 0; i < GRP_SYMS; i++) begin
            if (2'(i) < grp_cnt) begin
                masked[i*SYM_W +: SYM_W] = grp_syms[i*SYM_W +: SYM_W];
            end
        end
        shamt  = 8'(offset) * 8'(SYM_W);
        placed = BUF_W'(masked) << shamt;
    end

endmodule

// File: rtl/crossroad1_core_cpu_0_oci_dct_packer.sv
// Data-trace packer: packs 1-3 symbol groups LSB-first into a 15-symbol
// buffer, publishes the live buffer to the monitor and seals full, overflowing
// or flushed buffers into a one-entry output frame register.
//   clk, reset_n                  : clock, async active-low reset
//   in_valid/in_ready/in_syms/in_cnt : symbol group input handshake
//   flush / flush_done            : seal partial buffer / buffer drained
//   dct_buffer, dct_count         : live buffer and its fill count
//   out_valid/out_ready/out_frame/out_count : sealed frame handshake
//   frames_sealed                 : seal event counter (wraps)
module crossroad1_core_cpu_0_oci_dct_packer
    import crossroad1_core_cpu_0_oci_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [GRP_W-1:0]  in_syms,
    input  logic [1:0]        in_cnt,
    input  logic              flush,
    output logic              flush_done,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUF_W-1:0]  out_frame,
    output logic [CNT_W-1:0]  out_count,
    output logic [STAT_W-1:0] frames_sealed
);

    logic [BUF_W-1:0]  buf_q,  buf_d;
    dct_cnt_t          cnt_q,  cnt_d;
    logic              ovld_q, ovld_d;
    logic [BUF_W-1:0]  ofrm_q, ofrm_d;
    dct_cnt_t          ocnt_q, ocnt_d;
    logic [STAT_W-1:0] stat_q, stat_d;

    logic             slot_free;
    logic             fits;
    logic             accept;
    logic             seal;
    dct_cnt_t         ins_offset;
    logic [BUF_W-1:0] placed;

    assign slot_free = !ovld_q || out_ready;
    assign fits      = grp_fits(cnt_q, in_cnt);
    assign in_ready  = !flush && (fits || slot_free);
    assign accept    = in_valid && in_ready;

    // Flush blocks input, so a flush seal never carries a new group. Otherwise
    // a full buffer or a group that does not fit closes the current frame.
    always_comb begin
        if (flush) begin
            seal = (cnt_q != '0) && slot_free;
        end else begin
            seal = slot_free && ((cnt_q == dct_cnt_t'(BUF_SYMS)) || (accept && !fits));
        end
    end

    // A group accepted alongside a seal starts the fresh buffer at position 0.
    assign ins_offset = seal ? '0 : cnt_q;

    crossroad1_core_cpu_0_oci_dct_insert u_insert (
        .grp_syms (in_syms),
        .grp_cnt  (in_cnt),
        .offset   (ins_offset),
        .placed   (placed)
    );

    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        ovld_d = ovld_q;
        ofrm_d = ofrm_q;
        ocnt_d = ocnt_q;
        stat_d = stat_q;
        if (seal) begin
            ofrm_d = buf_q;
            ocnt_d = cnt_q;
            ovld_d = 1'b1;
            stat_d = stat_q + STAT_W'(1);
            buf_d  = accept ? placed : '0;
            cnt_d  = accept ? dct_cnt_t'(in_cnt) : '0;
        end else begin
            if (out_ready) begin
                ovld_d = 1'b0;
            end
            if (accept) begin
                buf_d = buf_q | placed;
                cnt_d = cnt_q + dct_cnt_t'(in_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            ovld_q <= 1'b0;
            ofrm_q <= '0;
            ocnt_q <= '0;
            stat_q <= '0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            ovld_q <= ovld_d;
            ofrm_q <= ofrm_d;
            ocnt_q <= ocnt_d;
            stat_q <= stat_d;
        end
    end

    assign flush_done    = flush && (cnt_q == '0);
    assign dct_buffer    = buf_q;
    assign dct_count     = cnt_q;
    assign out_valid     = ovld_q;
    assign out_frame     = ofrm_q;
    assign out_count     = ocnt_q;
    assign frames_sealed = stat_q;

endmodule

// File: tb/tb_crossroad1_core_cpu_0_oci_dct_packer.sv
module tb_crossroad1_core_cpu_0_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_syms;
    logic [1:0]  in_cnt;
    logic        flush;
    logic        flush_done;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_frame;
    logic [3:0]  out_count;
    logic [15:0] frames_sealed;

    logic        in_valid8;
    logic        in_ready8;
    logic [5:0]  in_syms8;
    logic [1:0]  in_cnt8;
    logic        flush8;
    logic        flush_done8;
    logic [29:0] dct_buffer8;
    logic [3:0]  dct_count8;
    logic        out_valid8;
    logic        out_ready8;
    logic [29:0] out_frame8;
    logic [3:0]  out_count8;
    logic [7:0]  frames_sealed8;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    logic [15:0] m_stat;
    logic [29:0] m_buf;
    int          m_cnt;

    crossroad1_core_cpu_0_oci_dct_packer dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_syms(in_syms), .in_cnt(in_cnt),
        .flush(flush), .flush_done(flush_done),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
        .out_count(out_count), .frames_sealed(frames_sealed)
    );

    // Narrow statistics counter so the wrap can be reached in a few hundred seals.
    crossroad1_core_cpu_0_oci_dct_packer #(.STAT_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_syms(in_syms8), .in_cnt(in_cnt8),
        .flush(flush8), .flush_done(flush_done8),
        .dct_buffer(dct_buffer8), .dct_count(dct_count8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_frame(out_frame8),
        .out_count(out_count8), .frames_sealed(frames_sealed8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: frames predicted by the tests are popped on each take.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL frame_unexpected got count=%0d frame=%h required none", out_count, out_frame);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_count, out_frame} !== mon_e)
                    $display("FAIL frame got count=%0d frame=%h required count=%0d frame=%h",
                             out_count, out_frame, mon_e[33:30], mon_e[29:0]);
                else
                    pass_cnt++;
            end
        end
    end

    function automatic logic [29:0] put(input logic [29:0] f, input int pos,
                                        input logic [5:0] s, input int c);
        logic [29:0] r;
        r = f;
        for (int j = 0; j < c; j++) r[2*(pos+j) +: 2] = s[2*j +: 2];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] s, input logic [1:0] c);
        int n;
        in_valid = 1'b1;
        in_syms  = s;
        in_cnt   = c;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #2;
        total_cnt++;
        if ({dct_buffer, dct_count, out_valid, out_frame, out_count, frames_sealed} !== '0)
            $display("FAIL reset_outputs got buf=%h cnt=%0d ov=%b stat=%0d required all 0",
                     dct_buffer, dct_count, out_valid, frames_sealed);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if (in_ready !== 1'b1 || dct_count !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL reset_release got rdy=%b cnt=%0d ov=%b required 1 0 0", in_ready, dct_count, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_fill;
        logic [29:0] f;
        logic [5:0]  s;
        f = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s = 6'($urandom);
            f = put(f, 3*k, s, 3);
            send(s, 2'd3);
            total_cnt++;
            if (dct_count !== 4'(3*(k+1)))
                $display("FAIL fill_count got %0d required %0d", dct_count, 3*(k+1));
            else pass_cnt++;
        end
        total_cnt++;
        if (dct_buffer !== f) $display("FAIL fill_buffer got %h required %h", dct_buffer, f);
        else pass_cnt++;
        exp_q.push_back({4'd15, f});
        m_stat++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_count !== 4'd15 || dct_count !== 4'd0 || frames_sealed !== 16'd1)
            $display("FAIL fill_seal got ov=%b ocnt=%0d cnt=%0d stat=%0d required 1 15 0 1",
                     out_valid, out_count, dct_count, frames_sealed);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL fill_take got ov=%b required 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        logic [29:0] f;
        logic [5:0]  s;
        f = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s = 6'($urandom);
            f = put(f, 3*k, s, (k == 4) ? 2 : 3);
            send(s, (k == 4) ? 2'd2 : 2'd3);
        end
        total_cnt++;
        if (dct_count !== 4'd14) $display("FAIL ovf_setup got %0d required 14", dct_count);
        else pass_cnt++;
        exp_q.push_back({4'd14, f});
        m_stat++;
        send(6'b10_01_11, 2'd3);
        total_cnt++;
        if (out_valid !== 1'b1 || out_count !== 4'd14 || out_frame !== f)
            $display("FAIL ovf_frame got ov=%b ocnt=%0d frame=%h required 1 14 %h", out_valid, out_count, out_frame, f);
        else pass_cnt++;
        total_cnt++;
        if (dct_buffer !== 30'h27 || dct_count !== 4'd3)
            $display("FAIL ovf_newbuf got buf=%h cnt=%0d required 27 3", dct_buffer, dct_count);
        else pass_cnt++;
        flush = 1'b1;
        exp_q.push_back({4'd3, 30'h27});
        m_stat++;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic test_backpressure;
        logic [29:0] a;
        logic [5:0]  s;
        logic [5:0]  b;
        logic [5:0]  g;
        out_ready = 1'b0;
        b = 6'($urandom);
        send(b, 2'd2);
        flush = 1'b1;
        exp_q.push_back({4'd2, put(30'd0, 0, b, 2)});
        m_stat++;
        tick();
        flush = 1'b0;
        a = '0;
        for (int k = 0; k < 5; k++) begin
            s = 6'($urandom);
            a = put(a, 3*k, s, (k == 4) ? 2 : 3);
            send(s, (k == 4) ? 2'd2 : 2'd3);
        end
        g = 6'($urandom);
        in_valid = 1'b1;
        in_syms  = g;
        in_cnt   = 2'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL bp_ready got %b required 0", in_ready);
            else pass_cnt++;
            total_cnt++;
            if (dct_count !== 4'd14 || dct_buffer !== a || out_valid !== 1'b1 ||
                out_count !== 4'd2 || out_frame !== put(30'd0, 0, b, 2))
                $display("FAIL bp_hold got cnt=%0d buf=%h ov=%b ocnt=%0d frame=%h", dct_count, dct_buffer,
                         out_valid, out_count, out_frame);
            else pass_cnt++;
        end
        tick();
        out_ready = 1'b1;
        exp_q.push_back({4'd14, a});
        m_stat++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release got %b required 1", in_ready);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_count !== 4'd14 || out_frame !== a ||
            dct_count !== 4'd2 || dct_buffer !== put(30'd0, 0, g, 2))
            $display("FAIL bp_accept got ov=%b ocnt=%0d cnt=%0d buf=%h required 1 14 2 %h",
                     out_valid, out_count, dct_count, dct_buffer, put(30'd0, 0, g, 2));
        else pass_cnt++;
        flush = 1'b1;
        exp_q.push_back({4'd2, put(30'd0, 0, g, 2)});
        m_stat++;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic test_flush;
        logic [29:0] f;
        logic [5:0]  s;
        out_ready = 1'b1;
        s = 6'($urandom);
        f = put(30'd0, 0, s, 3);
        send(s, 2'd3);
        s = 6'($urandom);
        f = put(f, 3, s, 2);
        send(s, 2'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_cnt   = 2'd1;
        exp_q.push_back({4'd5, f});
        m_stat++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0 || flush_done !== 1'b0)
            $display("FAIL flush_block got rdy=%b done=%b required 0 0", in_ready, flush_done);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_count !== 4'd5 || dct_count !== 4'd0 ||
            dct_buffer !== 30'd0 || flush_done !== 1'b1 || frames_sealed !== m_stat)
            $display("FAIL flush_seal got ov=%b ocnt=%0d cnt=%0d done=%b stat=%0d required 1 5 0 1 %0d",
                     out_valid, out_count, dct_count, flush_done, frames_sealed, m_stat);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || frames_sealed !== m_stat || flush_done !== 1'b1)
            $display("FAIL flush_empty got ov=%b stat=%0d done=%b required 0 %0d 1",
                     out_valid, frames_sealed, flush_done, m_stat);
        else pass_cnt++;
        flush = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [5:0] s;
        int         c;
        out_ready = 1'b1;
        m_buf = '0;
        m_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            c = $urandom_range(1, 3);
            s = 6'($urandom);
            if (m_cnt == 15) begin
                exp_q.push_back({4'd15, m_buf});
                m_stat++;
                m_buf = '0;
                m_cnt = 0;
            end
            if (m_cnt + c > 15) begin
                exp_q.push_back({4'(m_cnt), m_buf});
                m_stat++;
                m_buf = put(30'd0, 0, s, c);
                m_cnt = c;
            end else begin
                m_buf = put(m_buf, m_cnt, s, c);
                m_cnt = m_cnt + c;
            end
            send(s, 2'(c));
            total_cnt++;
            if (dct_count !== 4'(m_cnt) || dct_buffer !== m_buf)
                $display("FAIL b2b_buffer got cnt=%0d buf=%h required %0d %h", dct_count, dct_buffer, m_cnt, m_buf);
            else pass_cnt++;
        end
        flush = 1'b1;
        exp_q.push_back({4'(m_cnt), m_buf});
        m_stat++;
        tick();
        flush = 1'b0;
        tick();
        total_cnt++;
        if (frames_sealed !== m_stat || exp_q.size() != 0)
            $display("FAIL b2b_stat got stat=%0d pending=%0d required %0d 0", frames_sealed, exp_q.size(), m_stat);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        out_ready = 1'b0;
        send(6'b01_10_11, 2'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(6'b00_00_10, 2'd1);
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({dct_buffer, dct_count, out_valid, out_frame, out_count, frames_sealed} !== '0)
            $display("FAIL reset_async got buf=%h cnt=%0d ov=%b ocnt=%0d stat=%0d required all 0",
                     dct_buffer, dct_count, out_valid, out_count, frames_sealed);
        else pass_cnt++;
        exp_q.delete();
        m_stat = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if (in_ready !== 1'b1 || dct_count !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL reset_mid_release got rdy=%b cnt=%0d ov=%b required 1 0 0", in_ready, dct_count, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        out_ready8 = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            in_valid8 = 1'b1;
            in_cnt8   = 2'd1;
            in_syms8  = 6'($urandom);
            tick();
            in_valid8 = 1'b0;
            flush8    = 1'b1;
            tick();
            flush8    = 1'b0;
            if (i == 255 || i == 256 || i == 257) begin
                total_cnt++;
                if (frames_sealed8 !== 8'(i))
                    $display("FAIL wrap_count got %0d required %0d", frames_sealed8, 8'(i));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (frames_sealed !== m_stat) $display("FAIL wrap_main got %0d required %0d", frames_sealed, m_stat);
        else pass_cnt++;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_syms    = '0;
        in_cnt     = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_valid8  = 1'b0;
        in_syms8   = '0;
        in_cnt8    = '0;
        flush8     = 1'b0;
        out_ready8 = 1'b0;
        m_stat     = '0;
        m_buf      = '0;
        m_cnt      = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_midframe();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
